muldiv_sequencer: RTL

- Iterative multiply/divide controller that owns the HI/LO registers next to the EX-stage ALU.
- Sequences 32-step shift-add multiply and restoring divide for mult/multu/div/divu.
- Executes mthi/mtlo writes.
- Raises a pipeline stall when a HI/LO consumer or a new mul/div op arrives while an operation is in flight.

---
 rtl/muldiv_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide sequencer that owns HI/LO and requests pipeline stalls.
// Optional MULDIV_FAST_MUL_EN replaces the 32-step multiply with a single-cycle multiply.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            rd_req,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            stall_req
);
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_hi, r_lo, r_acc, r_low, r_opd;
    logic              r_neg_q, r_neg_r, r_is_div;
    logic              w_signed, w_is_mul, w_is_div, w_last;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [XLEN:0]     w_sum;
    logic [XLEN+1:0]   w_trial;
    logic [2*XLEN-1:0] w_prod, w_fix;

    assign w_is_mul = op == OP_MULT || op == OP_MULTU;
    assign w_is_div = op == OP_DIV || op == OP_DIVU;
    assign w_signed = op == OP_MULT || op == OP_DIV;
    assign w_a_mag  = (w_signed && a[XLEN-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[XLEN-1]) ? -b : b;
    assign w_last   = r_cnt == CNT_W'(XLEN - 1);
    // r_acc:r_low is the running product (mul) or remainder:dividend/quotient (div)
    assign w_sum    = {1'b0, r_acc} + (r_low[0] ? {1'b0, r_opd} : '0);
    assign w_trial  = {1'b0, r_acc, r_low[XLEN-1]} - {2'b0, r_opd};
`ifdef MULDIV_FAST_MUL_EN
    assign w_prod   = {{XLEN{1'b0}}, r_low} * {{XLEN{1'b0}}, r_opd};
`else
    assign w_prod   = {r_acc, r_low};
`endif
    assign w_fix    = r_neg_q ? -w_prod : w_prod;
    assign hi       = r_hi;
    assign lo       = r_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !start ? S_IDLE : w_is_mul ? S_MUL : w_is_div ? S_DIV : S_IDLE;
`ifdef MULDIV_FAST_MUL_EN
            S_MUL:   w_next = S_IDLE;
`else
            S_MUL:   w_next = w_last ? S_FIX : S_MUL;
`endif
            S_DIV:   w_next = w_last ? S_FIX : S_DIV;
            default: w_next = S_IDLE;
        endcase
        if (flush)
            w_next = S_IDLE;
    end

    always_comb begin
        busy      = r_state != S_IDLE;
        stall_req = busy && (rd_req || (start && op != OP_NONE && op != OP_RSVD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_low    <= '0;
            r_opd    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && op == OP_MTHI)
                        r_hi <= a;
                    if (start && op == OP_MTLO)
                        r_lo <= a;
                    if (start && (w_is_mul || w_is_div)) begin
                        r_acc    <= '0;
                        r_low    <= w_a_mag;
                        r_opd    <= w_b_mag;
                        r_cnt    <= '0;
                        // a zero divisor keeps the all-ones quotient unsigned
                        r_neg_q  <= w_signed && (a[XLEN-1] ^ b[XLEN-1]) && (|b);
                        r_neg_r  <= w_signed && a[XLEN-1];
                        r_is_div <= w_is_div;
                    end
                end
                S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                    {r_hi, r_lo} <= w_fix;
`else
                    r_acc <= w_sum[XLEN:1];
                    r_low <= {w_sum[0], r_low[XLEN-1:1]};
                    r_cnt <= r_cnt + 1'b1;
`endif
                end
                S_DIV: begin
                    r_acc <= w_trial[XLEN+1] ? {r_acc[XLEN-2:0], r_low[XLEN-1]} : w_trial[XLEN-1:0];
                    r_low <= {r_low[XLEN-2:0], ~w_trial[XLEN+1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                default: begin
                    r_hi <= r_is_div ? (r_neg_r ? -r_acc : r_acc) : w_fix[2*XLEN-1:XLEN];
                    r_lo <= r_is_div ? (r_neg_q ? -r_low : r_low) : w_fix[XLEN-1:0];
                end
            endcase
        end
    end
endmodule
